// File: rtl/cpu_core_pkg.sv
// rtl/cpu_core_pkg.sv - shared UART FSM state type and timing default for cpu_core
// Contents:
//   uart_state_t              common RX/TX frame state encoding
//   CLK_PER_HALF_BIT_DEFAULT  clocks per half UART bit (full bit = 2x)
//   CNT_W                     width of the bit-timing counters
package cpu_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int CLK_PER_HALF_BIT_DEFAULT = 217;
    localparam int CNT_W = 16;

endpackage

// File: rtl/cpu_core_uart_rx.sv
// rtl/cpu_core_uart_rx.sv - 8N1 UART receiver with 2-flop input synchroniser
// Ports:
//   clk       in   system clock, posedge
//   rstn      in   synchronous reset, active-high
//   rxd       in   asynchronous serial input, idle high
//   rx_data   out  last received byte
//   rx_valid  out  one-cycle pulse when rx_data holds a correctly framed byte
module uart_rx
    import cpu_core_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = CLK_PER_HALF_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(2 * CLK_PER_HALF_BIT - 1);

    logic [1:0]       sync_q;
    logic             rxd_s;
    uart_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shreg, shreg_next;
    logic             wait_high, wait_high_next;
    logic             valid_next;

    assign rxd_s   = sync_q[1];
    assign rx_data = shreg;

    always_ff @(posedge clk) begin
        if (rstn) begin
            sync_q    <= 2'b11;
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            wait_high <= 1'b0;
            rx_valid  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rxd};
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_next;
            shreg     <= shreg_next;
            wait_high <= wait_high_next;
            rx_valid  <= valid_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt + CNT_W'(1);
        bit_next       = bit_idx;
        shreg_next     = shreg;
        wait_high_next = wait_high;
        valid_next     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                // After a framing error the line may still be low; a new
                // start bit is only accepted once it has returned high.
                if (wait_high) begin
                    if (rxd_s) wait_high_next = 1'b0;
                end else if (!rxd_s) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt == HALF_M1) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rxd_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_next   = '0;
                    shreg_next = {rxd_s, shreg[7:1]};
                    if (bit_idx == 3'd7) state_next = ST_STOP;
                    else                 bit_next   = bit_idx + 3'd1;
                end
            end
            ST_STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                    if (rxd_s) valid_next     = 1'b1;
                    else       wait_high_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - UART host-link front end: byte echo and little-endian word assembly
// Ports:
//   clk              in   system clock, posedge
//   rstn             in   synchronous reset, active-high
//   rxd              in   serial input from computer side, idle high
//   txd              out  serial echo to computer side, idle high
//   output_register  out  last complete word {byte3,byte2,byte1,byte0}
module cpu_core
    import cpu_core_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = CLK_PER_HALF_BIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rxd,
    output logic        txd,
    output logic [31:0] output_register
);

    localparam logic [CNT_W-1:0] BIT_M1 = CNT_W'(2 * CLK_PER_HALF_BIT - 1);

    logic [7:0]       rx_data;
    logic             rx_valid;

    uart_state_t      tx_state, tx_state_next;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_next;
    logic [2:0]       tx_bit, tx_bit_next;
    logic [7:0]       tx_shreg, tx_shreg_next;
    logic             buf_valid, buf_valid_next;
    logic [7:0]       buf_data, buf_data_next;
    logic             tx_done, tx_free, load_buf, load_rx;

    logic [7:0]       slot0, slot1, slot2;
    logic [1:0]       idx;

    uart_rx #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_rx (
        .clk     (clk),
        .rstn    (rstn),
        .rxd     (rxd),
        .rx_data (rx_data),
        .rx_valid(rx_valid)
    );

    // All terms are flop outputs, so txd is a glitch-free decode.
    assign txd = (tx_state == ST_START) ? 1'b0 :
                 (tx_state == ST_DATA)  ? tx_shreg[0] : 1'b1;

    // The transmitter counts as free in the last stop-bit cycle so a queued
    // byte starts immediately after; this lets the buffer drain in the same
    // cycle that a new byte arrives, keeping echo order intact.
    assign tx_done  = (tx_state == ST_STOP) && (tx_cnt == BIT_M1);
    assign tx_free  = (tx_state == ST_IDLE) || tx_done;
    assign load_buf = tx_free && buf_valid;
    assign load_rx  = tx_free && !buf_valid && rx_valid;

    always_ff @(posedge clk) begin
        if (rstn) begin
            tx_state  <= ST_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shreg  <= '0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else begin
            tx_state  <= tx_state_next;
            tx_cnt    <= tx_cnt_next;
            tx_bit    <= tx_bit_next;
            tx_shreg  <= tx_shreg_next;
            buf_valid <= buf_valid_next;
            buf_data  <= buf_data_next;
        end
    end

    always_comb begin
        tx_state_next  = tx_state;
        tx_cnt_next    = tx_cnt + CNT_W'(1);
        tx_bit_next    = tx_bit;
        tx_shreg_next  = tx_shreg;
        buf_valid_next = buf_valid;
        buf_data_next  = buf_data;

        case (tx_state)
            ST_IDLE: tx_cnt_next = '0;
            ST_START: begin
                if (tx_cnt == BIT_M1) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_cnt == BIT_M1) begin
                    tx_cnt_next   = '0;
                    tx_shreg_next = {1'b1, tx_shreg[7:1]};
                    if (tx_bit == 3'd7) tx_state_next = ST_STOP;
                    else                tx_bit_next   = tx_bit + 3'd1;
                end
            end
            ST_STOP: begin
                if (tx_done) begin
                    tx_cnt_next   = '0;
                    tx_state_next = ST_IDLE;
                end
            end
            default: tx_state_next = ST_IDLE;
        endcase

        if (load_buf || load_rx) begin
            tx_state_next = ST_START;
            tx_cnt_next   = '0;
            tx_shreg_next = load_buf ? buf_data : rx_data;
        end

        // A byte not sent directly is parked if the buffer is empty or is
        // being emptied this cycle; otherwise it is dropped from the echo.
        if (rx_valid && !load_rx && (!buf_valid || load_buf)) begin
            buf_valid_next = 1'b1;
            buf_data_next  = rx_data;
        end else if (load_buf) begin
            buf_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            slot0           <= '0;
            slot1           <= '0;
            slot2           <= '0;
            idx             <= '0;
            output_register <= '0;
        end else if (rx_valid) begin
            idx <= idx + 2'd1;
            case (idx)
                2'd0:    slot0 <= rx_data;
                2'd1:    slot1 <= rx_data;
                2'd2:    slot2 <= rx_data;
                default: output_register <= {rx_data, slot2, slot1, slot0};
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - scoreboard bench for cpu_core echo and word assembly
module tb_cpu_core;

    localparam int HALF = 120;
    localparam int BITC = 2 * HALF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic        txd;
    logic [31:0] output_register;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  model_slot[4];
    int          model_idx  = 0;
    logic [31:0] model_word = 32'd0;

    cpu_core #(
        .CLK_PER_HALF_BIT(HALF)
    ) dut (
        .clk            (clk),
        .rstn           (rst),
        .rxd            (rxd),
        .txd            (txd),
        .output_register(output_register)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (BITC) @(negedge clk);
    endtask

    // Drives one frame; a good frame is pushed to the echo scoreboard and
    // folded into the word model, then output_register is compared.
    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        if (stop_bit) exp_q.push_back(data);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop_bit);
        rxd = 1'b1;
        if (stop_bit) begin
            model_slot[model_idx] = data;
            if (model_idx == 3)
                model_word = {model_slot[3], model_slot[2], model_slot[1], model_slot[0]};
            model_idx = (model_idx + 1) % 4;
        end
        check("out_reg", output_register, model_word);
    endtask

    // Echo decoder: samples txd mid-bit and pops the scoreboard.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                repeat (HALF) @(negedge clk);
                check("echo_start", 32'(txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BITC) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BITC) @(negedge clk);
                check("echo_stop", 32'(txd), 32'd1);
                check("echo_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("echo_byte", 32'(b), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) model_slot[i] = 8'h00;

        // reset held, then idle line after release
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            repeat (3) @(negedge clk);
            check("reset_txd", 32'(txd), 32'd1);
            check("reset_out", output_register, 32'd0);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (100) @(negedge clk);
            check("idle_txd", 32'(txd), 32'd1);
        end

        // first word, little-endian
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        check("word_12345678", output_register, 32'h1234_5678);
        repeat (2 * BITC) @(negedge clk);

        // framing error: no echo, no update; line returns high before next byte
        send_byte(8'hA5, 1'b0);
        repeat (2 * BITC) @(negedge clk);
        check("ferr_out", output_register, 32'h1234_5678);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        check("word_after_ferr", output_register, 32'h0403_0201);

        // short low glitch
        rxd = 1'b0;
        repeat (100) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * BITC) @(negedge clk);
        check("glitch_out", output_register, 32'h0403_0201);

        // back-to-back frames
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i), 1'b1);
            if (i == 3) check("word_03020100", output_register, 32'h0302_0100);
        end
        check("word_07060504", output_register, 32'h0706_0504);
        repeat (15 * BITC) @(negedge clk);
        check("echo_drain_b2b", 32'(exp_q.size()), 32'd0);

        // reset during a frame, after four data bits of 0x5A
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b1 : 1'b0);
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_out", output_register, 32'd0);
        model_idx  = 0;
        model_word = 32'd0;
        for (int i = 0; i < 4; i++) model_slot[i] = 8'h00;
        rst = 1'b0;
        repeat (2 * BITC) @(negedge clk);
        check("post_rst_txd", 32'(txd), 32'd1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        check("word_after_rst", output_register, 32'hEFBE_ADDE);
        repeat (15 * BITC) @(negedge clk);
        check("echo_drain_end", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
